// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared codes for the MEM->WB stage
// Purpose: write-back select codes, load funct3 codes and FSM state encodings
//          used by mem_wb_stage and load_align.
// Ports: none (package).
package mem_wb_stage_pkg;

    // Write-back source select
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;
    localparam logic [1:0] WB_SEL_RSVD = 2'd3;

    // Load funct3 codes (RV64I)
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    // Stage FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/mem_wb_stage_align.sv
// rtl/mem_wb_stage_align.sv - combinational load data alignment and extension
// Purpose: pick the addressed byte/half/word/double out of a raw doubleword,
//          sign- or zero-extend it, and flag misaligned accesses.
// Ports:
//   funct3_i   in   3     load type
//   addr_lo_i  in   3     byte offset within the doubleword
//   rdata_i    in   XLEN  raw doubleword
//   data_o     out  XLEN  aligned, extended load value
//   misalign_o out  1     access not naturally aligned
module load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3_i,
    input  logic [2:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        // Bring the addressed byte down to bit 0 before extension.
        shifted    = rdata_i >> {addr_lo_i, 3'b000};
        data_o     = shifted;
        misalign_o = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LBU: data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LH: begin
                data_o     = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
                misalign_o = addr_lo_i[0];
            end
            F3_LHU: begin
                data_o     = {{(XLEN-16){1'b0}}, shifted[15:0]};
                misalign_o = addr_lo_i[0];
            end
            F3_LW: begin
                data_o     = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
                misalign_o = |addr_lo_i[1:0];
            end
            F3_LWU: begin
                data_o     = {{(XLEN-32){1'b0}}, shifted[31:0]};
                misalign_o = |addr_lo_i[1:0];
            end
            F3_LD:   misalign_o = |addr_lo_i;
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM->WB pipeline stage driving the register-file write port
// Purpose: accept retiring ops, wait for load data, align/extend it, select the
//          write-back source and issue one registered register write per op.
// Optional: WB_RETIRE_CNT_EN adds retire_cnt, counting every WRITE cycle.
// Ports:
//   sys_clk, rst                clock, synchronous active-high reset
//   flush                       kill the op held or awaited here
//   ex_valid/ex_ready           op handshake from MEM
//   ex_rd, ex_reg_write, ex_wb_sel, ex_alu_result, ex_pc_plus4, ex_funct3, ex_addr_lo
//                               op fields
//   dmem_rvalid, dmem_rdata     load response
//   RegWrite, WriteAddr, WriteData  register-file write port
//   misalign_err                one-cycle pulse for a dropped misaligned load
//   retire_cnt                  (WB_RETIRE_CNT_EN only) WRITE-cycle counter
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic [1:0]        ex_wb_sel,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic [XLEN-1:0]   ex_pc_plus4,
    input  logic [2:0]        ex_funct3,
    input  logic [2:0]        ex_addr_lo,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              RegWrite,
    output logic [REG_AW-1:0] WriteAddr,
    output logic [XLEN-1:0]   WriteData,
    output logic              misalign_err
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]       retire_cnt
`endif
);

    logic [1:0]        state_q, state_d;
    logic              reg_write_q, reg_write_d;
    logic [REG_AW-1:0] write_addr_q, write_addr_d;
    logic [XLEN-1:0]   write_data_q, write_data_d;
    logic              misalign_q, misalign_d;
    // Load parked in WAIT
    logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
    logic              pend_we_q, pend_we_d;
    logic [2:0]        pend_funct3_q, pend_funct3_d;
    logic [2:0]        pend_addr_lo_q, pend_addr_lo_d;

    logic [2:0]        al_funct3, al_addr_lo;
    logic [XLEN-1:0]   al_data;
    logic              al_misalign;
    logic              accept, is_load, op_we;

    // One aligner serves both the accept-time misalignment check and the
    // data capture in WAIT; in WAIT it looks at the parked load fields.
    assign al_funct3  = (state_q == ST_WAIT) ? pend_funct3_q  : ex_funct3;
    assign al_addr_lo = (state_q == ST_WAIT) ? pend_addr_lo_q : ex_addr_lo;

    load_align #(.XLEN(XLEN)) u_align (
        .funct3_i   (al_funct3),
        .addr_lo_i  (al_addr_lo),
        .rdata_i    (dmem_rdata),
        .data_o     (al_data),
        .misalign_o (al_misalign)
    );

    assign ex_ready = (state_q == ST_IDLE) || (state_q == ST_WRITE);
    assign accept   = ex_valid && ex_ready && !flush;
    assign is_load  = (ex_wb_sel == WB_SEL_LOAD);
    assign op_we    = ex_reg_write && (ex_rd != '0) && (ex_wb_sel != WB_SEL_RSVD);

    always_comb begin
        state_d        = state_q;
        reg_write_d    = 1'b0;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        misalign_d     = 1'b0;
        pend_rd_d      = pend_rd_q;
        pend_we_d      = pend_we_q;
        pend_funct3_d  = pend_funct3_q;
        pend_addr_lo_d = pend_addr_lo_q;
        case (state_q)
            ST_IDLE, ST_WRITE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (is_load && !al_misalign) begin
                        state_d        = ST_WAIT;
                        pend_rd_d      = ex_rd;
                        pend_we_d      = op_we;
                        pend_funct3_d  = ex_funct3;
                        pend_addr_lo_d = ex_addr_lo;
                    end else begin
                        // Non-load, or a misaligned load retired without a write
                        state_d      = ST_WRITE;
                        reg_write_d  = op_we && !is_load;
                        misalign_d   = is_load;
                        write_addr_d = ex_rd;
                        write_data_d = (ex_wb_sel == WB_SEL_PC4) ? ex_pc_plus4 : ex_alu_result;
                    end
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end else if (dmem_rvalid) begin
                    state_d      = ST_WRITE;
                    reg_write_d  = pend_we_q;
                    write_addr_d = pend_rd_q;
                    write_data_d = al_data;
                end
            end
            ST_DRAIN: begin
                // The orphaned response is swallowed here
                if (dmem_rvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            reg_write_q    <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            misalign_q     <= 1'b0;
            pend_rd_q      <= '0;
            pend_we_q      <= 1'b0;
            pend_funct3_q  <= '0;
            pend_addr_lo_q <= '0;
        end else begin
            state_q        <= state_d;
            reg_write_q    <= reg_write_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
            misalign_q     <= misalign_d;
            pend_rd_q      <= pend_rd_d;
            pend_we_q      <= pend_we_d;
            pend_funct3_q  <= pend_funct3_d;
            pend_addr_lo_q <= pend_addr_lo_d;
        end
    end

    assign RegWrite     = reg_write_q;
    assign WriteAddr    = write_addr_q;
    assign WriteData    = write_data_q;
    assign misalign_err = misalign_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q;

    // Counts suppressed writes too; wraps naturally at 2^64.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (state_q == ST_WRITE) begin
            retire_cnt_q <= retire_cnt_q + 64'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        sys_clk;
    logic        rst;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic [1:0]  ex_wb_sel;
    logic [63:0] ex_alu_result;
    logic [63:0] ex_pc_plus4;
    logic [2:0]  ex_funct3;
    logic [2:0]  ex_addr_lo;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [63:0] WriteData;
    logic        misalign_err;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    int total = 0;
    int bad   = 0;

    mem_wb_stage #(.XLEN(64), .REG_AW(5)) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_wb_sel     (ex_wb_sel),
        .ex_alu_result (ex_alu_result),
        .ex_pc_plus4   (ex_pc_plus4),
        .ex_funct3     (ex_funct3),
        .ex_addr_lo    (ex_addr_lo),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .RegWrite      (RegWrite),
        .WriteAddr     (WriteAddr),
        .WriteData     (WriteData),
        .misalign_err  (misalign_err)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt    (retire_cnt)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference load: assemble the value byte by byte from the addressed
    // bytes, then fill the upper bytes with the sign or with zeros.
    function automatic void ref_load(input int f3, input int off, input logic [63:0] raw,
                                     output logic [63:0] val, output bit mis);
        int size;
        bit sgn;
        size = 1 << (f3 % 4);
        sgn  = (f3 < 4);
        mis  = (off % size) != 0;
        val  = '0;
        for (int b = 0; b < 8; b++) begin
            if (b < size) begin
                if (off + b < 8) val[b*8 +: 8] = raw[(off+b)*8 +: 8];
            end else begin
                val[b*8 +: 8] = (sgn && val[size*8-1]) ? 8'hFF : 8'h00;
            end
        end
    endfunction

    task automatic set_op(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                          input logic [63:0] alu, input logic [63:0] pc,
                          input logic [2:0] f3, input logic [2:0] off);
        ex_valid      = 1'b1;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_wb_sel     = sel;
        ex_alu_result = alu;
        ex_pc_plus4   = pc;
        ex_funct3     = f3;
        ex_addr_lo    = off;
    endtask

    // Present one load, run its whole life, check against the model.
    task automatic do_load(input string tag, input logic [4:0] rd, input logic rw,
                           input int f3, input int off, input logic [63:0] raw, input int gap);
        logic [63:0] ev;
        bit          mis;
        ref_load(f3, off, raw, ev, mis);
        set_op(rd, rw, 2'd1, {$urandom, $urandom}, {$urandom, $urandom}, f3[2:0], off[2:0]);
        chk({tag, ".ready_acc"}, 64'(ex_ready), 64'd1);
        dmem_rvalid = 1'b1;            // must be ignored in the accept cycle
        dmem_rdata  = ~raw;
        step();
        ex_valid    = 1'b0;
        dmem_rvalid = 1'b0;
        if (mis) begin
            chk({tag, ".mis_we"}, 64'(RegWrite), 64'd0);
            chk({tag, ".mis_err"}, 64'(misalign_err), 64'd1);
            step();
            chk({tag, ".mis_pulse"}, 64'(misalign_err), 64'd0);
        end else begin
            chk({tag, ".err0"}, 64'(misalign_err), 64'd0);
            for (int i = 0; i < gap; i++) begin
                chk({tag, ".ready_wait"}, 64'(ex_ready), 64'd0);
                step();
                chk({tag, ".we_wait"}, 64'(RegWrite), 64'd0);
            end
            chk({tag, ".ready_wait"}, 64'(ex_ready), 64'd0);
            dmem_rvalid = 1'b1;
            dmem_rdata  = raw;
            step();
            dmem_rvalid = 1'b0;
            dmem_rdata  = {$urandom, $urandom};
            chk({tag, ".we"}, 64'(RegWrite), 64'(rw && rd != 5'd0));
            chk({tag, ".addr"}, 64'(WriteAddr), 64'(rd));
            chk({tag, ".data"}, WriteData, ev);
            step();
            chk({tag, ".we_drop"}, 64'(RegWrite), 64'd0);
        end
    endtask

    initial begin
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  sel;
        logic [63:0] alu, pc;

        rst = 1'b1; flush = 1'b0; ex_valid = 1'b0;
        set_op(5'd0, 1'b0, 2'd0, 64'd0, 64'd0, 3'd0, 3'd0);
        ex_valid = 1'b0;
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        step(); step();
        chk("rst.we", 64'(RegWrite), 64'd0);
        chk("rst.addr", 64'(WriteAddr), 64'd0);
        chk("rst.data", WriteData, 64'd0);
        chk("rst.err", 64'(misalign_err), 64'd0);
        chk("rst.ready", 64'(ex_ready), 64'd1);
        rst = 1'b0;
        step();

        // 1: ALU op, write visible the cycle after accept
        set_op(5'd5, 1'b1, 2'd0, 64'h1234, 64'h0, 3'd0, 3'd0);
        step();
        ex_valid = 1'b0;
        chk("t1.we", 64'(RegWrite), 64'd1);
        chk("t1.addr", 64'(WriteAddr), 64'd5);
        chk("t1.data", WriteData, 64'h1234);
        step();
        chk("t1.we_drop", 64'(RegWrite), 64'd0);

        // Random non-load ops
        for (int i = 0; i < 10; i++) begin
            rd  = 5'($urandom_range(0, 31));
            rw  = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, 3));
            if (sel == 2'd1) sel = 2'd2;
            alu = {$urandom, $urandom};
            pc  = {$urandom, $urandom};
            set_op(rd, rw, sel, alu, pc, 3'($urandom), 3'($urandom));
            step();
            ex_valid = 1'b0;
            chk("rnd_alu.we", 64'(RegWrite), 64'(rw && rd != 5'd0 && sel != 2'd3));
            chk("rnd_alu.addr", 64'(WriteAddr), 64'(rd));
            if (sel != 2'd3) chk("rnd_alu.data", WriteData, (sel == 2'd2) ? pc : alu);
            step();
        end

        // 2: LB sign extension, rvalid two cycles after accept
        do_load("t2", 5'd9, 1'b1, 0, 3, 64'h00000000_80000000, 1);
        // 3: misaligned LH, then LWU from the upper word
        do_load("t3a", 5'd10, 1'b1, 1, 1, {$urandom, $urandom}, 0);
        do_load("t3b", 5'd11, 1'b1, 6, 4, 64'hDEADBEEF_00000000, 0);

        // Random loads over all types and offsets
        for (int i = 0; i < 20; i++) begin
            do_load("rnd_ld", 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 7)),
                    {$urandom, $urandom}, int'($urandom_range(0, 2)));
        end

        // 4: rd=0 never writes; PC+4 select
        set_op(5'd0, 1'b1, 2'd0, 64'hAA, 64'h0, 3'd0, 3'd0);
        step();
        chk("t4.rd0_we", 64'(RegWrite), 64'd0);
        set_op(5'd1, 1'b1, 2'd2, 64'hBB, 64'h8000_0004, 3'd0, 3'd0);
        step();
        ex_valid = 1'b0;
        chk("t4.pc4_we", 64'(RegWrite), 64'd1);
        chk("t4.pc4_data", WriteData, 64'h8000_0004);
        step();

        // 5: flush during WAIT; the late response is discarded
        set_op(5'd12, 1'b1, 2'd1, 64'h0, 64'h0, 3'd3, 3'd0);
        step();
        ex_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_op(5'd7, 1'b1, 2'd0, 64'h77, 64'h0, 3'd0, 3'd0);
        for (int i = 0; i < 2; i++) begin
            chk("t5.ready_drain", 64'(ex_ready), 64'd0);
            step();
            chk("t5.we_drain", 64'(RegWrite), 64'd0);
        end
        chk("t5.ready_drain", 64'(ex_ready), 64'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'h5555;
        step();
        dmem_rvalid = 1'b0;
        chk("t5.we_discard", 64'(RegWrite), 64'd0);
        chk("t5.ready_after", 64'(ex_ready), 64'd1);
        step();
        ex_valid = 1'b0;
        chk("t5.next_we", 64'(RegWrite), 64'd1);
        chk("t5.next_addr", 64'(WriteAddr), 64'd7);
        chk("t5.next_data", WriteData, 64'h77);
        step();

        // 6: back-to-back ALU ops after a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef WB_RETIRE_CNT_EN
        chk("t6.cnt0", retire_cnt, 64'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            set_op(5'(20 + i), 1'b1, 2'd0, 64'(100 + i), 64'h0, 3'd0, 3'd0);
            chk("t6.ready", 64'(ex_ready), 64'd1);
            step();
            chk("t6.we", 64'(RegWrite), 64'd1);
            chk("t6.data", WriteData, 64'(100 + i));
        end
        ex_valid = 1'b0;
        step();
        chk("t6.we_end", 64'(RegWrite), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        chk("t6.cnt3", retire_cnt, 64'd3);
`endif

        // rst while waiting for load data
        set_op(5'd13, 1'b1, 2'd1, 64'h0, 64'h0, 3'd3, 3'd0);
        step();
        ex_valid = 1'b0;
        chk("t6.wait_ready", 64'(ex_ready), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6.rst_we", 64'(RegWrite), 64'd0);
        chk("t6.rst_addr", 64'(WriteAddr), 64'd0);
        chk("t6.rst_data", WriteData, 64'd0);
        chk("t6.rst_err", 64'(misalign_err), 64'd0);
        chk("t6.rst_ready", 64'(ex_ready), 64'd1);
`ifdef WB_RETIRE_CNT_EN
        chk("t6.rst_cnt", retire_cnt, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
